// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus: raw A/B inputs, enable and terminal count in,
// decoded position with direction/step/error pulses out.
interface quad_decoder_if;
  logic       a_in;
  logic       b_in;
  logic       en;
  logic [3:0] N;
  logic [3:0] pos;
  logic       dir;
  logic       step;
  logic       err;

  modport master (output a_in, b_in, en, N, input pos, dir, step, err);
  modport slave  (input a_in, b_in, en, N, output pos, dir, step, err);
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder with wrap-around position 0..N, all state on the falling clock edge.
// Optional glitch filter on the synchronized A/B state: define QUAD_GLITCH_FILTER_EN.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input logic           clk,
  input logic           rst,
  quad_decoder_if.slave bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("quad_decoder: SYNC_STAGES must be 2 or 3");
  end
  if (FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_bad_filt
    $error("quad_decoder: FILT_CYCLES must be 1..15");
  end

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             s;
  logic [1:0]             p_q, p_d;
  logic                   p_valid_q, p_valid_d;
  logic [3:0]             pos_q, pos_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   up, down, illegal;

  always_ff @(negedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.a_in};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.b_in};
    end
  end

  assign s = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef QUAD_GLITCH_FILTER_EN
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;

  // A new state must survive FILT_CYCLES identical samples; any change of candidate restarts the count.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (!p_valid_q || s == p_q) begin
      cnt_d = '0;
    end else if (s != cand_q || cnt_q == 4'd0) begin
      cand_d = s;
      cnt_d  = 4'd1;
    end else if (cnt_q >= 4'(FILT_CYCLES)) begin
      accept = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  always_comb begin
    accept = p_valid_q && (s != p_q);
  end
`endif

  always_comb begin
    up      = 1'b0;
    down    = 1'b0;
    illegal = 1'b0;
    if (accept) begin
      case ({p_q, s})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: up      = 1'b1;
        4'b0100, 4'b1101, 4'b1011, 4'b0010: down    = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // N is looked at only when a step lands, so a new N never rewrites the current position.
  always_comb begin
    p_d       = p_q;
    p_valid_d = 1'b1;
    pos_d     = pos_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    if (!p_valid_q) begin
      p_d = s;
    end else if (accept) begin
      p_d   = s;
      err_d = illegal;
      if (bus.en && up) begin
        pos_d  = (pos_q >= bus.N) ? 4'd0 : pos_q + 4'd1;
        dir_d  = 1'b1;
        step_d = 1'b1;
      end else if (bus.en && down) begin
        pos_d  = (pos_q == 4'd0 || pos_q > bus.N) ? bus.N : pos_q - 4'd1;
        dir_d  = 1'b0;
        step_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      pos_q     <= '0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random moves checked against a
// phase-arithmetic model of the encoder (00,01,11,10 = phase 0..3).
module tb_quad_decoder;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 3;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + 1 + FILT_CYCLES;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_decoder_if bus ();

  quad_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] m_p;
  logic [3:0] m_pos;
  logic       m_dir;
  logic       e_step, e_err, e_dir;
  logic [3:0] e_pos;
  logic       o_step, o_err, o_dir, o_stray;
  logic [3:0] o_pos;

  function automatic int phase(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] code(input int ph);
    case (ph % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Reference model: one encoder move to s, using en/N as currently driven.
  task automatic model_move(input logic [1:0] s);
    int d;
    d = (phase(s) - phase(m_p) + 4) % 4;
    e_step = 1'b0;
    e_err  = 1'b0;
    if (d == 2) begin
      e_err = 1'b1;
    end else if (d == 1 && bus.en) begin
      m_pos  = (m_pos >= bus.N) ? 4'd0 : 4'(m_pos + 1);
      m_dir  = 1'b1;
      e_step = 1'b1;
    end else if (d == 3 && bus.en) begin
      m_pos  = (m_pos == 0 || m_pos > bus.N) ? bus.N : 4'(m_pos - 1);
      m_dir  = 1'b0;
      e_step = 1'b1;
    end
    m_p   = s;
    e_pos = m_pos;
    e_dir = m_dir;
  endtask

  // Drive one A/B change and capture outputs exactly LAT falling edges later;
  // any pulse on another edge of the window is flagged as stray.
  task automatic move(input logic [1:0] s);
    @(posedge clk);
    bus.a_in = s[1];
    bus.b_in = s[0];
    o_stray  = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      #1;
      if (k < LAT && (bus.step || bus.err)) o_stray = 1'b1;
    end
    o_step = bus.step;
    o_err  = bus.err;
    o_pos  = bus.pos;
    o_dir  = bus.dir;
    @(negedge clk);
    #1;
    if (bus.step || bus.err) o_stray = 1'b1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    rst      = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    m_p   = 2'b00;
    m_pos = 4'd0;
    m_dir = 1'b1;
  endtask

  task automatic test_reset;
    bus.en = 1'b1;
    bus.N  = 4'd9;
    @(posedge clk);
    rst      = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    #1;
    total++;
    if ({bus.pos, bus.dir} !== {4'd0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_pos_dir: got pos=%0d dir=%b, want pos=0 dir=1", bus.pos, bus.dir);
    end
    total++;
    if ({bus.step, bus.err} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_pulses: got step=%b err=%b, want 0 0", bus.step, bus.err);
    end
    do_reset;
  endtask

  task automatic test_forward_wrap;
    int steps;
    logic [1:0] s;
    do_reset;
    bus.N  = 4'd9;
    bus.en = 1'b1;
    steps  = 0;
    for (int i = 1; i <= 10; i++) begin
      s = code(i);
      move(s);
      model_move(s);
      steps += int'(o_step);
      total++;
      if ({o_step, o_err, o_pos, o_dir, o_stray} !== {e_step, e_err, e_pos, e_dir, 1'b0}) begin
        bad++;
        $display("[TB] FAIL fwd_move%0d: got step=%b err=%b pos=%0d dir=%b stray=%b, want %b %b %0d %b 0",
                 i, o_step, o_err, o_pos, o_dir, o_stray, e_step, e_err, e_pos, e_dir);
      end
      total++;
      if (o_pos !== 4'(i % 10)) begin
        bad++;
        $display("[TB] FAIL fwd_pos%0d: got %0d, want %0d", i, o_pos, i % 10);
      end
    end
    total++;
    if (steps != 10 || o_dir !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fwd_summary: got steps=%0d dir=%b, want 10 1", steps, o_dir);
    end
  endtask

  task automatic test_reverse_from_zero;
    do_reset;
    bus.N  = 4'd5;
    bus.en = 1'b1;
    move(2'b10);
    model_move(2'b10);
    total++;
    if ({o_step, o_err, o_pos, o_dir, o_stray} !== {e_step, e_err, e_pos, e_dir, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rev_model: got step=%b err=%b pos=%0d dir=%b stray=%b, want %b %b %0d %b 0",
               o_step, o_err, o_pos, o_dir, o_stray, e_step, e_err, e_pos, e_dir);
    end
    total++;
    if ({o_pos, o_dir, o_step} !== {4'd5, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL rev_wrap: got pos=%0d dir=%b step=%b, want 5 0 1", o_pos, o_dir, o_step);
    end
  endtask

  task automatic test_illegal;
    do_reset;
    bus.N  = 4'd9;
    bus.en = 1'b1;
    move(2'b11);
    model_move(2'b11);
    total++;
    if ({o_err, o_step, o_pos, o_dir, o_stray} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL illegal_jump: got err=%b step=%b pos=%0d dir=%b stray=%b, want 1 0 0 1 0",
               o_err, o_step, o_pos, o_dir, o_stray);
    end
    move(2'b10);
    model_move(2'b10);
    total++;
    if ({o_err, o_step, o_pos, o_dir, o_stray} !== {1'b0, 1'b1, 4'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL illegal_recover: got err=%b step=%b pos=%0d dir=%b stray=%b, want 0 1 1 1 0",
               o_err, o_step, o_pos, o_dir, o_stray);
    end
  endtask

  task automatic test_enable;
    logic [1:0] seq [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic       ens [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset;
    bus.N = 4'd9;
    for (int i = 0; i < 7; i++) begin
      bus.en = ens[i];
      move(seq[i]);
      model_move(seq[i]);
      total++;
      if ({o_step, o_err, o_pos, o_dir, o_stray} !== {e_step, e_err, e_pos, e_dir, 1'b0}) begin
        bad++;
        $display("[TB] FAIL enable_move%0d: got step=%b err=%b pos=%0d dir=%b stray=%b, want %b %b %0d %b 0",
                 i, o_step, o_err, o_pos, o_dir, o_stray, e_step, e_err, e_pos, e_dir);
      end
    end
    total++;
    if (o_pos !== 4'd3) begin
      bad++;
      $display("[TB] FAIL enable_final_pos: got %0d, want 3", o_pos);
    end
  endtask

  task automatic test_n_change;
    do_reset;
    bus.en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      bus.N = 4'd9;
      for (int i = 1; i <= 7; i++) begin
        move(code(phase(m_p) + 1));
        model_move(code(phase(m_p) + 1));
      end
      bus.N = 4'd4;
      if (pass == 0) begin
        move(code(phase(m_p) + 1));
        model_move(code(phase(m_p) + 1));
      end else begin
        move(code(phase(m_p) + 3));
        model_move(code(phase(m_p) + 3));
      end
      total++;
      if ({o_step, o_pos, o_dir, o_stray} !== {1'b1, (pass == 0) ? 4'd0 : 4'd4, (pass == 0), 1'b0}) begin
        bad++;
        $display("[TB] FAIL n_change_pass%0d: got step=%b pos=%0d dir=%b stray=%b, want 1 %0d %b 0",
                 pass, o_step, o_pos, o_dir, o_stray, (pass == 0) ? 0 : 4, (pass == 0));
      end
      if (pass == 0) begin
        do_reset;
      end
    end
  endtask

  task automatic test_n_zero;
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b01, 2'b00};
    do_reset;
    bus.N  = 4'd0;
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      move(seq[i]);
      model_move(seq[i]);
      total++;
      if ({o_step, o_err, o_pos, o_dir, o_stray} !== {1'b1, 1'b0, 4'd0, e_dir, 1'b0}) begin
        bad++;
        $display("[TB] FAIL n_zero_move%0d: got step=%b err=%b pos=%0d dir=%b stray=%b, want 1 0 0 %b 0",
                 i, o_step, o_err, o_pos, o_dir, o_stray, e_dir);
      end
    end
  endtask

  task automatic test_reset_in_flight;
    int pulses;
    bus.en = 1'b1;
    bus.N  = 4'd9;
    pulses = 0;
    @(posedge clk);
    bus.a_in = code(phase(m_p) + 1) >> 1;
    bus.b_in = code(phase(m_p) + 1) & 2'b01;
    @(negedge clk);
    @(posedge clk);
    rst      = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (bus.step || bus.err) pulses++;
    end
    @(posedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      #1;
      if (bus.step || bus.err) pulses++;
    end
    m_p   = 2'b00;
    m_pos = 4'd0;
    m_dir = 1'b1;
    total++;
    if (pulses != 0 || {bus.pos, bus.dir} !== {4'd0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_in_flight: got pulses=%0d pos=%0d dir=%b, want 0 0 1", pulses, bus.pos, bus.dir);
    end
  endtask

  task automatic test_random;
    int r;
    logic [1:0] s;
    do_reset;
    bus.N = 4'd7;
    for (int i = 0; i < 120; i++) begin
      if (i % 10 == 0) bus.N = 4'($urandom_range(0, 15));
      bus.en = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r <= 5)      s = code(phase(m_p) + 1);
      else if (r <= 8) s = code(phase(m_p) + 3);
      else             s = code(phase(m_p) + 2);
      move(s);
      model_move(s);
      total++;
      if ({o_step, o_err, o_pos, o_dir, o_stray} !== {e_step, e_err, e_pos, e_dir, 1'b0}) begin
        bad++;
        $display("[TB] FAIL random_move%0d: got step=%b err=%b pos=%0d dir=%b stray=%b, want %b %b %0d %b 0",
                 i, o_step, o_err, o_pos, o_dir, o_stray, e_step, e_err, e_pos, e_dir);
      end
    end
  endtask

`ifdef QUAD_GLITCH_FILTER_EN
  task automatic test_glitch_filter;
    int pulses, steps;
    do_reset;
    bus.N  = 4'd9;
    bus.en = 1'b1;
    pulses = 0;
    @(posedge clk);
    bus.a_in = 1'b1;
    repeat (2) @(posedge clk);
    bus.a_in = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      #1;
      if (bus.step || bus.err) pulses++;
    end
    total++;
    if (pulses != 0 || bus.pos !== 4'd0) begin
      bad++;
      $display("[TB] FAIL glitch_short: got pulses=%0d pos=%0d, want 0 0", pulses, bus.pos);
    end
    steps = 0;
    @(posedge clk);
    bus.a_in = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      #1;
      if (bus.step) steps++;
    end
    model_move(2'b10);
    total++;
    if (steps != 1 || {bus.pos, bus.dir} !== {e_pos, e_dir}) begin
      bad++;
      $display("[TB] FAIL glitch_stable: got steps=%0d pos=%0d dir=%b, want 1 %0d %b", steps, bus.pos, bus.dir, e_pos, e_dir);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    bus.en   = 1'b1;
    bus.N    = 4'd9;
    test_reset;
    test_forward_wrap;
    test_reverse_from_zero;
    test_illegal;
    test_enable;
    test_n_change;
    test_n_zero;
    test_reset_in_flight;
    test_random;
`ifdef QUAD_GLITCH_FILTER_EN
    test_glitch_filter;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL provide parameter: SYNC_STAGES, 2, input synchronizer depth (legal 2-3).
REQ-002 SHALL provide parameter: FILT_CYCLES, 3, consecutive stable samples a new A/B state needs before acceptance (filter build only, legal 1-15).
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on the falling edge.
REQ-004 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port: a_in  input  1  quadrature channel A, asynchronous.
REQ-006 SHALL provide port: b_in  input  1  quadrature channel B, asynchronous.
REQ-007 SHALL provide port: en  input  1  position update enable.
REQ-008 SHALL provide port: N  input  4  terminal count; position range 0..N.
REQ-009 SHALL provide port: pos  output  4  decoded position, registered.
REQ-010 SHALL provide port: dir  output  1  last accepted direction (1 = up, 0 = down).
REQ-011 SHALL provide port: step  output  1  one-cycle pulse per accepted position change.
REQ-012 SHALL provide port: err  output  1  one-cycle pulse on an illegal (two-bit) state change.

Function
REQ-013 SHALL pass a_in and b_in through SYNC_STAGES flops each before any use.
REQ-014 SHALL form state S = {A,B} from the synchronized bits and keep the previously accepted state P.
REQ-015 SHALL decode P->S = 00->01, 01->11, 11->10, 10->00 as an up step; the reverse sequence as a down step.
REQ-016 SHALL treat S == P as no event: pos, dir unchanged; step = 0, err = 0.
REQ-017 SHALL treat a change in both bits (00<->11, 01<->10) as illegal: pulse err for one cycle, set P = S, leave pos and dir unchanged, step = 0.
REQ-018 SHALL on an up step set pos = 0 if pos >= N, else pos + 1.
REQ-019 SHALL on a down step set pos = N if pos == 0 or pos > N, else pos - 1.
REQ-020 SHALL hold pos at 0 when N == 0; step and dir still respond to legal steps.
REQ-021 SHALL, on a legal step with en = 1, update pos and dir and pulse step on the same falling edge.
REQ-022 SHALL, with en = 0, keep tracking P (legal and illegal) and still pulse err, but not change pos or dir and not pulse step.
REQ-023 SHALL have latency (filter not built) of SYNC_STAGES + 1 falling edges from an A/B input edge to the pos/step update.
REQ-024 SHALL sample N combinationally at each step; a change of N takes effect on the next step with no retroactive pos correction.

Reset
REQ-025 SHALL, with rst = 1 at a falling edge, set pos = 0, dir = 1, step = 0, err = 0, clear synchronizer flops and filter counter, and clear the P-valid flag.
REQ-026 SHALL, on the first sample after reset release, load P from S with no step or err (P-valid set).
REQ-027 SHALL give reset priority over every event; a step in flight when rst asserts is discarded.

Configuration
REQ-028 SHALL provide macro QUAD_GLITCH_FILTER_EN: when defined, S is accepted only after it differs from P and is held identical for FILT_CYCLES consecutive samples (a changing candidate restarts the count), adding FILT_CYCLES edges of latency; when undefined, S is accepted every cycle and FILT_CYCLES is ignored.

Verification
REQ-029 SHALL show: reset, N=9, en=1, drive 10 forward transitions from 00 -> pos 1..9 then 0, ten step pulses, dir=1.
REQ-030 SHALL show: from pos=0, N=5, one reverse transition 00->10 -> pos=5, dir=0, one step pulse.
REQ-031 SHALL show: jump 00->11 -> err pulses once, pos and dir unchanged, step=0; next legal 11->10 counts up normally.
REQ-032 SHALL show: en=0 during 3 forward transitions, then en=1 and 1 forward -> pos advances by exactly 1.
REQ-033 SHALL show: pos=7, change N to 4, one up step -> pos=0; repeat from pos=7 with one down step -> pos=4.
REQ-034 SHALL show: with QUAD_GLITCH_FILTER_EN, FILT_CYCLES=3, a 2-cycle pulse on a_in -> no step/err; a 3-cycle-stable change -> exactly one step.
